systolic_array_ctrl: RTL and testbench

- Sequencer for an N x N array of floating-point multiply-accumulate PEs (one load_in input and one done_pe output per PE).
- Clears the PE accumulators, then steps the operand buffers through K + 2N - 2 skewed wavefronts.
- For each wavefront: pulses the shared load to all PEs, then waits until every PE has reported completion.
- Signals completion of the whole matrix product to the host.

---
 rtl/systolic_array_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_systolic_array_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_array_ctrl
//
// Sequencer for an N x N array of multiply-accumulate PEs. A run clears the PE
// accumulators and then steps the operand buffers through k_len + 2N - 2
// skewed wavefronts. For each wavefront it reads the buffers, broadcasts a
// load to every PE and waits until each PE has pulsed its done line once.
// Completion of the whole product is signalled with a one-cycle done pulse.
//
// Optional feature (macro WDOG_EN): a watchdog bounds each WAIT to TIMEOUT
// cycles. On expiry the run is abandoned, err is raised and done still pulses.
// Without the macro, err is tied low and WAIT may last indefinitely.
//
// Parameters:
//   N        array dimension (N*N PEs)
//   KW       width of k_len
//   SW       width of the step counter and rd_addr (holds k_len + 2N - 2)
//   TIMEOUT  watchdog limit in cycles per WAIT (WDOG_EN only)
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   start    in   begin a product; sampled only in IDLE
//   k_len    in   inner dimension K, captured when start is accepted
//   pe_done  in   per-PE single-cycle completion pulses, bit i = PE i
//   pe_clr   out  one-cycle accumulator clear
//   rd_en    out  operand buffer read strobe
//   rd_addr  out  wavefront index; holds its last value outside FETCH
//   load_pe  out  broadcast load to all PEs
//   busy     out  high in every state except IDLE
//   done     out  one-cycle completion pulse
//   err      out  watchdog error, sticky until the next accepted start
// -----------------------------------------------------------------------------
module systolic_array_ctrl #(
    parameter int N       = 4,
    parameter int KW      = 8,
    parameter int SW      = KW + 4,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic [N*N-1:0]  pe_done,
    output logic            pe_clr,
    output logic            rd_en,
    output logic [SW-1:0]   rd_addr,
    output logic            load_pe,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_FINISH
    } state_t;

    // Extra wavefronts needed to drain the skew out of the array.
    localparam logic [SW-1:0] SKEW = SW'(2 * N - 2);

    state_t          state, state_next;
    logic [SW-1:0]   step, step_next;
    logic [SW-1:0]   total, total_next;
    logic            k_zero, k_zero_next;
    logic [N*N-1:0]  seen, seen_next;
    logic            all_seen;
    logic            wd_hit;

    // A PE finishing in the current cycle counts immediately, so the next
    // FETCH follows the last pulse without an extra cycle.
    assign all_seen = &(seen | pe_done);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_next  = state;
        step_next   = step;
        total_next  = total;
        k_zero_next = k_zero;
        seen_next   = seen;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    total_next  = SW'(k_len) + SKEW;
                    k_zero_next = (k_len == '0);
                    step_next   = '0;
                    state_next  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_next = k_zero ? S_FINISH : S_FETCH;
            end
            S_FETCH: begin
                state_next = S_LOAD;
            end
            S_LOAD: begin
                seen_next  = pe_done;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                seen_next = seen | pe_done;
                if (all_seen) begin
                    step_next  = step + SW'(1);
                    state_next = (step_next == total) ? S_FINISH : S_FETCH;
                end else if (wd_hit) begin
                    state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and registered outputs. Outputs are decoded from the next state so
    // each strobe is high exactly while the FSM sits in the matching state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            step    <= '0;
            total   <= '0;
            k_zero  <= 1'b0;
            seen    <= '0;
            pe_clr  <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            load_pe <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples values from before this clock edge.
            state   <= state_next;
            step    <= step_next;
            total   <= total_next;
            k_zero  <= k_zero_next;
            seen    <= seen_next;
            pe_clr  <= (state_next == S_CLEAR);
            rd_en   <= (state_next == S_FETCH);
            load_pe <= (state_next == S_LOAD);
            busy    <= (state_next != S_IDLE);
            done    <= (state_next == S_FINISH);
            if (state_next == S_FETCH) begin
                rd_addr <= step_next;
            end
        end
    end

`ifdef WDOG_EN
    // -------------------------------------------------------------------------
    // Watchdog: counts cycles spent in the current WAIT; restarts from zero on
    // every entry (from LOAD). Expiry on the TIMEOUT-th WAIT cycle.
    // -------------------------------------------------------------------------
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] wd_cnt;

    assign wd_hit = (state == S_WAIT) && !all_seen && (wd_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == S_LOAD) begin
            wd_cnt <= '0;
        end else if (state == S_WAIT) begin
            wd_cnt <= wd_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state == S_IDLE && start) begin
            err <= 1'b0;
        end else if (wd_hit) begin
            err <= 1'b1;
        end
    end
`else
    assign wd_hit = 1'b0;
    assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_array_ctrl
//
// Directed bench for systolic_array_ctrl with N=2. A small PE responder pulses
// each pe_done bit a programmable number of cycles after every load_pe (0 means
// the PE never answers). A monitor counts strobes and logs rd_addr / load
// times. Outputs are sampled 1 time unit after the falling edge.
// -----------------------------------------------------------------------------
module tb_systolic_array_ctrl;

    localparam int N       = 2;
    localparam int KW      = 8;
    localparam int SW      = KW + 4;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [KW-1:0]   k_len;
    logic [N*N-1:0]  pe_done;
    logic            pe_clr;
    logic            rd_en;
    logic [SW-1:0]   rd_addr;
    logic            load_pe;
    logic            busy;
    logic            done;
    logic            err;

    systolic_array_ctrl #(
        .N       (N),
        .KW      (KW),
        .SW      (SW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .k_len   (k_len),
        .pe_done (pe_done),
        .pe_clr  (pe_clr),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .load_pe (load_pe),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // PE responder and monitor
    int pe_lat [N*N];
    int since = 255;
    int n_load, n_rd, n_clr, n_done;
    int load_t [16];
    logic [SW-1:0] addr_log [16];

    initial pe_done = '0;

    always @(negedge clk) begin
        if (load_pe) begin
            if (n_load < 16) load_t[n_load] = cyc;
            n_load++;
            since   = 0;
            pe_done = '0;
        end else begin
            if (since < 255) since++;
            for (int i = 0; i < N*N; i++)
                pe_done[i] = (pe_lat[i] != 0) && (since == pe_lat[i]);
        end
        if (rd_en) begin
            if (n_rd < 16) addr_log[n_rd] = rd_addr;
            n_rd++;
        end
        if (pe_clr) n_clr++;
        if (done)   n_done++;
    end

    int n_checks = 0;
    int n_pass   = 0;
    bit hold_start = 1'b0;
    int clr_at;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_load = 0; n_rd = 0; n_clr = 0; n_done = 0;
    endtask

    task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
        pe_lat[0] = l0; pe_lat[1] = l1; pe_lat[2] = l2; pe_lat[3] = l3;
    endtask

    task automatic launch(input int k, input bit hold);
        @(negedge clk);
        #1;
        k_len      = KW'(k);
        start      = 1'b1;
        hold_start = hold;
    endtask

    // Returns the cycle (relative to the start cycle) in which done was seen,
    // or -1 if the bound expired.
    task automatic wait_done(output int n);
        n      = -1;
        clr_at = -1;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            #1;
            if (!hold_start) start = 1'b0;
            if (pe_clr && clr_at < 0) clr_at = i;
            if (done) begin
                n = i;
                return;
            end
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {13'd0, pe_clr, rd_en, load_pe, busy, done, err, rd_addr};
    endfunction

    int lat;
    int waited;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        k_len = '0;
        set_lat(5, 5, 5, 5);
        clear_counts();
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", out_vec(), 32'd0);
        rst = 1'b0;

        // Run 1: k_len=3, all PEs answer 5 cycles after load -> 5 wavefronts of 7 cycles
        clear_counts();
        launch(3, 1'b0);
        wait_done(lat);
        check("r1_latency", lat, 37);
        check("r1_clr_count", n_clr, 1);
        check("r1_load_count", n_load, 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("r1_rd_addr%0d", i), addr_log[i], i);
        check("r1_done_count", n_done, 1);
        @(negedge clk); #1;
        check("r1_busy_after_done", busy, 0);

        // Run 2: k_len=1, staggered finishes 1,3,3,6 -> 3 wavefronts of 8 cycles
        set_lat(1, 3, 3, 6);
        clear_counts();
        launch(1, 1'b0);
        wait_done(lat);
        check("r2_latency", lat, 26);
        check("r2_load_count", n_load, 3);
        check("r2_gap01", load_t[1] - load_t[0], 8);
        check("r2_gap12", load_t[2] - load_t[1], 8);

        // Run 3: k_len=0 -> clear then done, no reads, no loads
        clear_counts();
        launch(0, 1'b0);
        wait_done(lat);
        check("r3_clr_cycle", clr_at, 1);
        check("r3_latency", lat, 2);
        check("r3_rd_count", n_rd, 0);
        check("r3_load_count", n_load, 0);

        // Run 4: start held high, k_len=2, latency 2 -> 4 wavefronts of 4 cycles
        set_lat(2, 2, 2, 2);
        clear_counts();
        launch(2, 1'b1);
        wait_done(lat);
        check("r4_latency", lat, 18);
        check("r4_load_count", n_load, 4);
        check("r4_done_count", n_done, 1);
        @(negedge clk); #1;
        check("r4_idle_gap_busy", busy, 0);
        @(negedge clk); #1;
        check("r4_restart_clr", pe_clr, 1);
        hold_start = 1'b0;
        start      = 1'b0;
        wait_done(lat);
        check("r4_second_done", n_done, 2);

        // Run 5: reset during WAIT of the second wavefront, then a fresh run
        set_lat(4, 4, 4, 4);
        clear_counts();
        launch(3, 1'b0);
        waited = 0;
        for (int i = 0; i < 200 && n_load < 2; i++) begin
            @(negedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk); #1;
        check("r5_in_wait_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("r5_reset_outputs", out_vec(), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("r5_no_done_on_reset", n_done, 0);
        clear_counts();
        launch(3, 1'b0);
        wait_done(lat);
        check("r5_fresh_latency", lat, 32);
        check("r5_fresh_first_addr", addr_log[0], 0);
        check("r5_fresh_load_count", n_load, 5);

`ifdef WDOG_EN
        // Run 6: PE3 never answers -> timeout after 16 WAIT cycles, err + done
        set_lat(1, 1, 1, 0);
        clear_counts();
        launch(1, 1'b0);
        wait_done(lat);
        check("r6_wdog_latency", lat, 20);
        check("r6_err_set", err, 1);
        check("r6_load_count", n_load, 1);
        @(negedge clk); #1;
        check("r6_err_sticky", err, 1);
        launch(0, 1'b0);
        wait_done(lat);
        check("r6_err_cleared", err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
